dlsc_pcie_s6_tx_arbiter: RTL

Final transmit stage of the Spartan-6 PCIe bridge. It merges two 32-bit TLP streams into the hard core's TRN transmit interface: outbound requests from the outbound TLP generator, and completions from the inbound completer. It gates packet starts on link state and transmit buffer availability. It grants core-initiated configuration transmits between packets and counts core-side TLP drops.

---
 rtl/dlsc_pcie_s6_tx_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dlsc_pcie_s6_tx_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : dlsc_pcie_s6_tx_arbiter
// Description : Final transmit stage of the Spartan-6 PCIe bridge. Merges the
//               outbound request stream and the completion stream into the
//               hard core's TRN transmit interface, one whole TLP at a time.
//               Packet starts are gated on link-up and on free transmit
//               buffers. Core-initiated config transmits are granted only
//               between packets. Core-side TLP drops are counted.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               req_* (ready/valid/data/last) - outbound request TLP stream
//               cpl_* (ready/valid/data/last) - completion TLP stream
//               trn_td/tsof_n/teof_n/tsrc_rdy_n/tdst_rdy_n - TRN tx data path
//               trn_tsrc_dsc_n/tstr_n/terrfwd_n - tied inactive (1)
//               trn_tbuf_av            - free transmit buffers in the core
//               trn_terr_drop_n        - core dropped a TLP (active low)
//               trn_tcfg_req_n/gnt_n   - core config transmit handshake
//               trn_lnk_up_n           - link up (active low)
//               drop_cnt               - saturating count of drop cycles
// Revision    : 1.0 - initial release
//==============================================================================
module dlsc_pcie_s6_tx_arbiter #(
    parameter int BUF_MIN    = 2,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    output logic                  req_ready,
    input  logic                  req_valid,
    input  logic [31:0]           req_data,
    input  logic                  req_last,

    output logic                  cpl_ready,
    input  logic                  cpl_valid,
    input  logic [31:0]           cpl_data,
    input  logic                  cpl_last,

    output logic [31:0]           trn_td,
    output logic                  trn_tsof_n,
    output logic                  trn_teof_n,
    output logic                  trn_tsrc_rdy_n,
    input  logic                  trn_tdst_rdy_n,
    output logic                  trn_tsrc_dsc_n,
    output logic                  trn_tstr_n,
    output logic                  trn_terrfwd_n,
    input  logic [5:0]            trn_tbuf_av,
    input  logic                  trn_terr_drop_n,
    input  logic                  trn_tcfg_req_n,
    output logic                  trn_tcfg_gnt_n,
    input  logic                  trn_lnk_up_n,

    output logic [DROP_CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_CPL   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic [5:0]            c_BUF_MIN  = 6'(BUF_MIN);
    localparam logic [DROP_CNT_W-1:0] c_DROP_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_rr;          // last served source: 0 = req, 1 = cpl
    logic                  w_rr_nxt;
    logic                  r_first;       // next accepted beat opens a packet
    logic [31:0]           r_td;
    logic                  r_sof_n;
    logic                  r_eof_n;
    logic                  r_src_rdy_n;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic                  w_out_free;
    logic                  w_start_ok;
    logic                  w_req_elig;
    logic                  w_cpl_elig;
    logic                  w_sel_cpl;
    logic                  w_sel_valid;
    logic [31:0]           w_sel_data;
    logic                  w_sel_last;
    logic                  w_sel_ready;
    logic                  w_load;
    logic                  w_flush_entry;
    logic                  w_cfg_gnt;

    // Output register can take a beat when empty or when its beat leaves now.
    assign w_out_free = r_src_rdy_n | ~trn_tdst_rdy_n;
    assign w_start_ok = ~trn_lnk_up_n & (trn_tbuf_av >= c_BUF_MIN);
    assign w_req_elig = req_valid & w_start_ok;
    assign w_cpl_elig = cpl_valid & w_start_ok;

    // In FLUSH the locked source is remembered by the round-robin pointer,
    // which always holds the source of the most recently started packet.
    assign w_sel_cpl   = (r_state == ST_CPL) || ((r_state == ST_FLUSH) && r_rr);
    assign w_sel_valid = w_sel_cpl ? cpl_valid : req_valid;
    assign w_sel_data  = w_sel_cpl ? cpl_data  : req_data;
    assign w_sel_last  = w_sel_cpl ? cpl_last  : req_last;

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_nxt      = r_rr;
        w_sel_ready   = 1'b0;
        w_load        = 1'b0;
        w_flush_entry = 1'b0;
        w_cfg_gnt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A pending config request blocks new starts until granted,
                // so it always wins over both data sources.
                if (!trn_tcfg_req_n) begin
                    w_cfg_gnt = w_out_free;
                end else if (w_req_elig && w_cpl_elig) begin
                    w_rr_nxt    = ~r_rr;
                    w_state_nxt = r_rr ? ST_REQ : ST_CPL;
                end else if (w_req_elig) begin
                    w_rr_nxt    = 1'b0;
                    w_state_nxt = ST_REQ;
                end else if (w_cpl_elig) begin
                    w_rr_nxt    = 1'b1;
                    w_state_nxt = ST_CPL;
                end
            end
            ST_REQ, ST_CPL: begin
                if (trn_lnk_up_n) begin
                    w_flush_entry = 1'b1;
                    w_state_nxt   = ST_FLUSH;
                end else begin
                    w_sel_ready = w_out_free;
                    w_load      = w_sel_valid & w_out_free;
                    if (w_load && w_sel_last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                // Drain the rest of the interrupted packet without sending it.
                w_sel_ready = 1'b1;
                if (w_sel_valid && w_sel_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr        <= 1'b0;
            r_first     <= 1'b1;
            r_td        <= 32'd0;
            r_sof_n     <= 1'b1;
            r_eof_n     <= 1'b1;
            r_src_rdy_n <= 1'b1;
            r_drop_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;

            if (r_state == ST_IDLE) begin
                r_first <= 1'b1;
            end else if (w_load) begin
                r_first <= 1'b0;
            end

            if (w_flush_entry) begin
                r_src_rdy_n <= 1'b1;
                r_sof_n     <= 1'b1;
                r_eof_n     <= 1'b1;
            end else if (w_load) begin
                r_td        <= w_sel_data;
                r_sof_n     <= ~r_first;
                r_eof_n     <= ~w_sel_last;
                r_src_rdy_n <= 1'b0;
            end else if (!trn_tdst_rdy_n) begin
                r_src_rdy_n <= 1'b1;
                r_sof_n     <= 1'b1;
                r_eof_n     <= 1'b1;
            end

            if (!trn_terr_drop_n && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + c_DROP_ONE;
            end
        end
    end

    assign req_ready      = w_sel_ready & ~w_sel_cpl;
    assign cpl_ready      = w_sel_ready &  w_sel_cpl;
    assign trn_td         = r_td;
    assign trn_tsof_n     = r_sof_n;
    assign trn_teof_n     = r_eof_n;
    assign trn_tsrc_rdy_n = r_src_rdy_n;
    assign trn_tsrc_dsc_n = 1'b1;
    assign trn_tstr_n     = 1'b1;
    assign trn_terrfwd_n  = 1'b1;
    // Grant is held off while reset is applied.
    assign trn_tcfg_gnt_n = ~(w_cfg_gnt & ~rst);
    assign drop_cnt       = r_drop_cnt;

endmodule
`default_nettype wire
